// File: rtl/ad7124_conv_sequencer.sv
// AD7124 conversion sequencer: polls STATUS until RDY_n=0, then reads DATA and emits it tagged with its channel.
// Latency: sample_valid 1 clk after the DATA spi_rd_vld; no backpressure, the SPI handshake is pulse-only.
module ad7124_conv_sequencer #(
    parameter int unsigned CW       = 16,
    parameter logic [7:0]  STAT_CMD = 8'h40,
    parameter logic [7:0]  DATA_CMD = 8'h42,
    parameter int unsigned GAP_CYC  = 64,
    parameter int unsigned POLL_CYC = 256,
    parameter int unsigned TMO_CYC  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        continuous,
    input  logic        err_clr,
    output logic [7:0]  spi_cmd,
    output logic        spi_cmd_vld,
    input  logic [23:0] spi_rd_data,
    input  logic        spi_rd_vld,
    output logic [23:0] sample_data,
    output logic [3:0]  sample_chan,
    output logic        sample_valid,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [3:0] {
        IDLE, ISSUE_S, WAIT_S, CHECK, POLL, GAP_D, ISSUE_D, WAIT_D, DONE, GAP_S
    } state_t;

    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    spi_cmd_q, spi_cmd_d;
    logic          spi_cmd_vld_q, spi_cmd_vld_d;
    logic          rdy_n_q, rdy_n_d;
    logic [3:0]    chan_q, chan_d;
    logic [23:0]   sample_data_q, sample_data_d;
    logic [3:0]    sample_chan_q, sample_chan_d;
    logic          sample_valid_q, sample_valid_d;
    logic          err_q, err_d;
    logic          oneshot_q, oneshot_d;
    logic          tmo_hit;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        spi_cmd_d      = spi_cmd_q;
        rdy_n_d        = rdy_n_q;
        chan_d         = chan_q;
        sample_data_d  = sample_data_q;
        sample_chan_d  = sample_chan_q;
        sample_valid_d = 1'b0;
        oneshot_d      = oneshot_q & enable;
        tmo_hit        = 1'b0;

        case (state_q)
            IDLE: begin
                // a finished single-shot run stays parked until enable is dropped
                if (enable && !err_q && !oneshot_q) state_d = ISSUE_S;
            end
            ISSUE_S: state_d = WAIT_S;
            WAIT_S: begin
                if (spi_rd_vld) begin
                    rdy_n_d = spi_rd_data[23];
                    chan_d  = spi_rd_data[19:16];
                    state_d = enable ? CHECK : IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: state_d = rdy_n_q ? POLL : GAP_D;
            POLL: begin
                if (!enable)                state_d = IDLE;
                else if (cnt_q == POLL_LAST) state_d = ISSUE_S;
                else                        cnt_d = cnt_q + 1'b1;
            end
            GAP_D: begin
                if (!enable)               state_d = IDLE;
                else if (cnt_q == GAP_LAST) state_d = ISSUE_D;
                else                       cnt_d = cnt_q + 1'b1;
            end
            ISSUE_D: state_d = WAIT_D;
            WAIT_D: begin
                if (spi_rd_vld) begin
                    sample_data_d  = spi_rd_data;
                    sample_chan_d  = chan_q;
                    sample_valid_d = 1'b1;
                    state_d        = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (continuous && enable) begin
                    state_d = GAP_S;
                end else begin
                    state_d   = IDLE;
                    oneshot_d = enable;
                end
            end
            GAP_S: begin
                if (!enable)               state_d = IDLE;
                else if (cnt_q == GAP_LAST) state_d = ISSUE_S;
                else                       cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        spi_cmd_vld_d = (state_d == ISSUE_S) || (state_d == ISSUE_D);
        if (state_d == ISSUE_S) spi_cmd_d = STAT_CMD;
        if (state_d == ISSUE_D) spi_cmd_d = DATA_CMD;

        // a timeout in the same cycle as err_clr must leave the flag set
        err_d = tmo_hit ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            spi_cmd_q      <= STAT_CMD;
            spi_cmd_vld_q  <= 1'b0;
            rdy_n_q        <= 1'b0;
            chan_q         <= '0;
            sample_data_q  <= '0;
            sample_chan_q  <= '0;
            sample_valid_q <= 1'b0;
            err_q          <= 1'b0;
            oneshot_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            spi_cmd_q      <= spi_cmd_d;
            spi_cmd_vld_q  <= spi_cmd_vld_d;
            rdy_n_q        <= rdy_n_d;
            chan_q         <= chan_d;
            sample_data_q  <= sample_data_d;
            sample_chan_q  <= sample_chan_d;
            sample_valid_q <= sample_valid_d;
            err_q          <= err_d;
            oneshot_q      <= oneshot_d;
        end
    end

    assign spi_cmd      = spi_cmd_q;
    assign spi_cmd_vld  = spi_cmd_vld_q;
    assign sample_data  = sample_data_q;
    assign sample_chan  = sample_chan_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != IDLE);
    assign err_timeout  = err_q;

endmodule
